// File: rtl/hazard_stall.sv
// Pipeline interlock: load-use and HI/LO busy stalls for the ID stage,
// plus sequencing of the multi-cycle mult/div busy window.
module hazard_stall #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memread_IE,
  input  logic [4:0]       Rt_addr_IE,
  input  logic [4:0]       Rs_addr_ID,
  input  logic [4:0]       Rt_addr_ID,
  input  logic             uses_rt_ID,
  input  logic             md_start_ID,
  input  logic             md_is_div_ID,
  input  logic             md_read_ID,
  input  logic             flush_in,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             bubble_ID_IE,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lat_m1;
  logic          load_use;
  logic          md_hazard;
  logic          stall;
  logic          issue;

  assign load_use = memread_IE && (Rt_addr_IE != 5'd0) &&
                    ((Rt_addr_IE == Rs_addr_ID) ||
                     (uses_rt_ID && (Rt_addr_IE == Rt_addr_ID)));

  assign md_busy   = (state_q == BUSY);
  assign md_done   = md_busy && (cnt_q == '0);
  assign md_hazard = md_busy && !md_done &&
                     (md_start_ID || md_read_ID);

  assign stall        = !flush_in && (load_use || md_hazard);
  assign stall_PC     = stall;
  assign stall_IF_ID  = stall;
  assign bubble_ID_IE = stall;

  assign issue  = md_start_ID && !flush_in && !stall;
  assign lat_m1 = md_is_div_ID ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = lat_m1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (issue) begin
          cnt_d = lat_m1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall.sv
// Directed bench for hazard_stall: load-use, mult/div busy window,
// flush priority, async reset abort and counter saturation.
module tb_hazard_stall;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic        memread_IE;
  logic [4:0]  Rt_addr_IE;
  logic [4:0]  Rs_addr_ID;
  logic [4:0]  Rt_addr_ID;
  logic        uses_rt_ID;
  logic        md_start_ID;
  logic        md_is_div_ID;
  logic        md_read_ID;
  logic        flush_in;
  logic        stall_PC, stall_IF_ID, bubble_ID_IE;
  logic        md_busy, md_done;
  logic [15:0] stall_cnt;
  logic        s_PC, s_IF_ID, s_bub, s_busy, s_done;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall dut (
    .clk(clk), .rst_n(rst_n),
    .memread_IE(memread_IE), .Rt_addr_IE(Rt_addr_IE),
    .Rs_addr_ID(Rs_addr_ID), .Rt_addr_ID(Rt_addr_ID),
    .uses_rt_ID(uses_rt_ID), .md_start_ID(md_start_ID),
    .md_is_div_ID(md_is_div_ID), .md_read_ID(md_read_ID),
    .flush_in(flush_in),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID),
    .bubble_ID_IE(bubble_ID_IE), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt)
  );

  hazard_stall #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst2_n),
    .memread_IE(memread_IE), .Rt_addr_IE(Rt_addr_IE),
    .Rs_addr_ID(Rs_addr_ID), .Rt_addr_ID(Rt_addr_ID),
    .uses_rt_ID(uses_rt_ID), .md_start_ID(md_start_ID),
    .md_is_div_ID(md_is_div_ID), .md_read_ID(md_read_ID),
    .flush_in(flush_in),
    .stall_PC(s_PC), .stall_IF_ID(s_IF_ID),
    .bubble_ID_IE(s_bub), .md_busy(s_busy),
    .md_done(s_done), .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    memread_IE   = 1'b0;
    Rt_addr_IE   = 5'd0;
    Rs_addr_ID   = 5'd0;
    Rt_addr_ID   = 5'd0;
    uses_rt_ID   = 1'b0;
    md_start_ID  = 1'b0;
    md_is_div_ID = 1'b0;
    md_read_ID   = 1'b0;
    flush_in     = 1'b0;
    #1;
  endtask

  function automatic logic [2:0] st();
    return {stall_PC, stall_IF_ID, bubble_ID_IE};
  endfunction

  initial begin
    logic seen;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    clr();
    #10;
    chk("rst_stall", 32'(st()), 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    tick();

    // reset in the middle of a divide
    md_start_ID  = 1'b1;
    md_is_div_ID = 1'b1;
    #1;
    chk("rs_issue_stall", 32'(st()), 32'd0);
    tick();
    clr();
    for (int i = 0; i < 21; i++) tick();
    chk("rs_busy_pre", 32'(md_busy), 32'd1);
    chk("rs_done_pre", 32'(md_done), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", 32'(md_busy), 32'd0);
    chk("rs_done", 32'(md_done), 32'd0);
    chk("rs_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (md_done || md_busy) seen = 1'b1;
    end
    chk("rs_no_done", 32'(seen), 32'd0);

    // load-use on rs
    memread_IE = 1'b1;
    Rt_addr_IE = 5'd5;
    Rs_addr_ID = 5'd5;
    #1;
    chk("lu_rs_stall", 32'(st()), 32'd7);
    tick();
    exp_cnt += 1;
    memread_IE = 1'b0;
    #1;
    chk("lu_rs_clear", 32'(st()), 32'd0);
    chk("lu_rs_cnt", 32'(stall_cnt), 32'(exp_cnt));
    memread_IE = 1'b1;
    Rt_addr_IE = 5'd0;
    Rs_addr_ID = 5'd0;
    #1;
    chk("lu_r0", 32'(st()), 32'd0);
    Rt_addr_IE = 5'd5;
    Rs_addr_ID = 5'd1;
    Rt_addr_ID = 5'd5;
    uses_rt_ID = 1'b0;
    #1;
    chk("lu_rt_unused", 32'(st()), 32'd0);
    uses_rt_ID = 1'b1;
    #1;
    chk("lu_rt_used", 32'(st()), 32'd7);
    clr();
    tick();
    chk("lu_cnt2", 32'(stall_cnt), 32'(exp_cnt));

    // mult then mflo
    md_start_ID = 1'b1;
    #1;
    chk("mul_issue", 32'(st()), 32'd0);
    tick();
    clr();
    md_read_ID = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mul_stall%0d", i), 32'(st()), 32'd7);
      chk($sformatf("mul_busy%0d", i), 32'(md_busy), 32'd1);
      chk($sformatf("mul_ndone%0d", i), 32'(md_done), 32'd0);
      tick();
      exp_cnt += 1;
    end
    chk("mul_done", 32'(md_done), 32'd1);
    chk("mul_done_nostall", 32'(st()), 32'd0);
    tick();
    clr();
    chk("mul_idle", 32'(md_busy), 32'd0);
    chk("mul_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // back-to-back divides
    md_start_ID  = 1'b1;
    md_is_div_ID = 1'b1;
    #1;
    tick();
    for (int i = 1; i <= 31; i++) begin
      chk($sformatf("div_stall%0d", i), 32'(st()), 32'd7);
      chk($sformatf("div_busy%0d", i), 32'(md_busy), 32'd1);
      chk($sformatf("div_ndone%0d", i), 32'(md_done), 32'd0);
      tick();
      exp_cnt += 1;
    end
    chk("div_done1", 32'(md_done), 32'd1);
    chk("div_reissue", 32'(st()), 32'd0);
    tick();
    clr();
    seen = 1'b0;
    for (int i = 33; i <= 63; i++) begin
      if (!md_busy || md_done) seen = 1'b1;
      tick();
    end
    chk("div_busy_cont", 32'(seen), 32'd0);
    chk("div_busy64", 32'(md_busy), 32'd1);
    chk("div_done2", 32'(md_done), 32'd1);
    tick();
    chk("div_idle", 32'(md_busy), 32'd0);
    chk("div_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // flush beats load-use and issue
    memread_IE  = 1'b1;
    Rt_addr_IE  = 5'd5;
    Rs_addr_ID  = 5'd5;
    md_start_ID = 1'b1;
    flush_in    = 1'b1;
    #1;
    chk("fl_stall", 32'(st()), 32'd0);
    tick();
    clr();
    chk("fl_busy", 32'(md_busy), 32'd0);
    chk("fl_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // saturation on the 4-bit instance
    rst2_n = 1'b0;
    #1;
    chk("sat_rst", 32'(s_cnt), 32'd0);
    rst2_n = 1'b1;
    memread_IE = 1'b1;
    Rt_addr_IE = 5'd5;
    Rs_addr_ID = 5'd5;
    #1;
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_cnt += 1;
    end
    chk("sat_14", 32'(s_cnt), 32'd14);
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_cnt += 1;
    end
    chk("sat_hold", 32'(s_cnt), 32'd15);
    chk("sat_main", 32'(stall_cnt), 32'(exp_cnt));
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
